mips_mc_ctrl: RTL and testbench

Multicycle MIPS main control unit: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It produces the select inputs for the datapath 2:1 and 4:1 multiplexers (ALU B-source, PC-source, address source, writeback source) plus all register and memory write strobes. It sits directly upstream of the datapath `mux4`/`mux2` instances and the PC/IR/register-file enables. It stalls on a memory ready handshake.

---
 rtl/mips_mc_ctrl.sv | 140 ++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main control: Moore FSM driving datapath mux selects and
// write strobes, stalling FETCH/MEMRD/MEMWR on the memory ready handshake.
module mips_mc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR  = 4'd2,  MEMRD  = 4'd3,
        MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTEXE   = 4'd6,  RTWB   = 4'd7,
        BEQ     = 4'd8,  ADDIEXE = 4'd9,  ADDIWB  = 4'd10, JUMP   = 4'd11,
        START   = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t cur, nxt;
    logic   bad_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= START;
            illegal <= 1'b0;
        end else begin
            cur     <= nxt;
            illegal <= (cur == DECODE) && bad_op;
        end
    end

    assign state = cur;

    always_comb begin
        nxt         = FETCH;
        bad_op      = 1'b0;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        aluop       = 2'b00;
        case (cur)
            START: nxt = FETCH;
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                // PC+4 and IR load commit only on the cycle memory delivers
                irwrite = mem_ready;
                pcwrite = mem_ready;
                nxt     = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_R:         nxt = RTEXE;
                    OP_BEQ:       nxt = BEQ;
                    OP_J:         nxt = JUMP;
                    OP_ADDI:      nxt = ADDIEXE;
                    default: begin
                        nxt    = FETCH;
                        bad_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                nxt     = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                nxt     = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                nxt      = mem_ready ? FETCH : MEMWR;
            end
            RTEXE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                nxt     = RTWB;
            end
            RTWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            BEQ: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcsrc       = 2'b01;
                pcwritecond = 1'b1;
            end
            ADDIEXE: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                nxt     = ADDIWB;
            end
            ADDIWB: regwrite = 1'b1;
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: nxt = FETCH;
        endcase
    end
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed table-driven bench for mips_mc_ctrl: one row per clock cycle with
// inputs and the expected state and output bundle for that cycle.
module tb_mips_mc_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    mips_mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regdst,
    //  regwrite,alusrca,alusrcb[1:0],pcsrc[1:0],aluop[1:0],illegal}
    localparam logic [16:0] O_ZERO  = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] O_FRDY  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] O_FWAIT = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] O_DEC   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] O_MADR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] O_MRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] O_MWB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] O_MWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] O_RTEX  = 17'b0_0_0_0_0_0_0_0_0_1_00_00_10_0;
    localparam logic [16:0] O_RTWB  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] O_BEQ   = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] O_AIWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [16:0] O_JMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_10_00_0;
    localparam logic [16:0] O_FILL  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_1;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100, J = 6'b000010, AI = 6'b001000;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] out;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [16:0] outs();
        return {pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                memtoreg, regdst, regwrite, alusrca, alusrcb, pcsrc, aluop,
                illegal};
    endfunction

    task automatic add(input logic r, input logic [5:0] o, input logic m,
                       input logic [3:0] s, input logic [16:0] e);
        vec_t v;
        v.rst = r; v.op = o; v.rdy = m; v.st = s; v.out = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [16:0] act,
                       input logic [16:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; op = 6'd0; mem_ready = 1'b0;
        // reset held with arbitrary inputs, then released
        add(0, 6'($urandom), 1'($urandom), 12, O_ZERO);
        add(0, 6'($urandom), 1'($urandom), 12, O_ZERO);
        add(1, R,  1, 12, O_ZERO);
        // R-type
        add(1, R,  1, 0,  O_FRDY);
        add(1, R,  1, 1,  O_DEC);
        add(1, R,  1, 6,  O_RTEX);
        add(1, R,  1, 7,  O_RTWB);
        // lw with two MEMRD stalls
        add(1, LW, 1, 0,  O_FRDY);
        add(1, LW, 1, 1,  O_DEC);
        add(1, LW, 1, 2,  O_MADR);
        add(1, LW, 0, 3,  O_MRD);
        add(1, LW, 0, 3,  O_MRD);
        add(1, LW, 1, 3,  O_MRD);
        add(1, LW, 1, 4,  O_MWB);
        // sw then beq back-to-back
        add(1, SW, 1, 0,  O_FRDY);
        add(1, SW, 1, 1,  O_DEC);
        add(1, SW, 1, 2,  O_MADR);
        add(1, SW, 1, 5,  O_MWR);
        add(1, BQ, 1, 0,  O_FRDY);
        add(1, BQ, 1, 1,  O_DEC);
        add(1, BQ, 1, 8,  O_BEQ);
        // fetch stall, then j
        add(1, J,  0, 0,  O_FWAIT);
        add(1, J,  0, 0,  O_FWAIT);
        add(1, J,  0, 0,  O_FWAIT);
        add(1, J,  1, 0,  O_FRDY);
        add(1, J,  1, 1,  O_DEC);
        add(1, J,  1, 11, O_JMP);
        // addi
        add(1, AI, 1, 0,  O_FRDY);
        add(1, AI, 1, 1,  O_DEC);
        add(1, AI, 1, 9,  O_MADR);
        add(1, AI, 1, 10, O_AIWB);
        // illegal opcode: pulse visible only in the following FETCH
        add(1, R,  1, 0,  O_FRDY);
        add(1, BAD,1, 1,  O_DEC);
        add(1, J,  1, 0,  O_FILL);
        add(1, J,  0, 1,  O_DEC);
        add(1, LW, 0, 11, O_JMP);
        // sw with MEMWR wait, op changes ignored, then mid-cycle reset
        add(1, SW, 1, 0,  O_FRDY);
        add(1, SW, 1, 1,  O_DEC);
        add(1, SW, 1, 2,  O_MADR);
        add(1, LW, 0, 5,  O_MWR);
        add(1, LW, 0, 5,  O_MWR);
        add(0, LW, 1, 12, O_ZERO);
        add(1, R,  1, 12, O_ZERO);
        add(1, BAD,1, 0,  O_FRDY);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n = tbl[i].rst; op = tbl[i].op; mem_ready = tbl[i].rdy;
            #1;
            chk($sformatf("row%0d_state", i), 17'(state), 17'(tbl[i].st));
            chk($sformatf("row%0d_outs", i), outs(), tbl[i].out);
            chk($sformatf("row%0d_rdwr_excl", i), 17'(memread & memwrite), 17'd0);
            chk($sformatf("row%0d_pcw_excl", i), 17'(pcwrite & pcwritecond), 17'd0);
        end

        // reset asserted while illegal is high clears it asynchronously
        @(negedge clk);
        op = BAD; mem_ready = 1'b1;
        #1 chk("ill_decode_state", 17'(state), 17'd1);
        @(negedge clk);
        #1 chk("ill_pulse", 17'(illegal), 17'd1);
        rst_n = 1'b0;
        #1;
        chk("ill_reset_clr", 17'(illegal), 17'd0);
        chk("ill_reset_state", 17'(state), 17'd12);

        // CPI check: j with mem_ready tied high takes 3 cycles
        @(negedge clk);
        rst_n = 1'b1; op = J; mem_ready = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 chk("j_cpi_refetch", 17'(state), 17'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
